tag_arb_cmp: RTL



---
 rtl/tag_arb_cmp.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tag_arb_cmp.sv
// tag_arb_cmp: arbitrates NR_PORTS cache requesters onto one shared set of
// tag/data SRAM ports (fixed-priority or round-robin, with optional lock for
// read-modify-write). One cycle after a read grant it compares the granted
// port's late tag against every way and reports the hit vector, hit index and
// a sticky multi-hit error.
//
// Ports (per-port buses are flattened, port p occupies slice [p*W +: W]):
//   clk_i, rst_ni       clock, synchronous active-low reset
//   req_i               per-port way-select request (port active if any bit set)
//   lock_i              granted port keeps ownership next cycle
//   gnt_o               one-hot grant (combinational)
//   addr_i/wdata_i/we_i/be_i  per-port request fields
//   tag_i               per-port tag, valid one cycle after grant
//   req_o/addr_o/wdata_o/we_o/be_o  granted port's fields to the SRAMs
//   way_tag_i/way_valid_i/way_data_i  stored SRAM contents per way
//   rdata_o             way_data_i passed through
//   cmp_valid_o/cmp_port_o  compare result valid / owning port (one-hot)
//   hit_way_o/hit_o/hit_idx_o  per-way hit, any hit, lowest hitting way
//   multi_hit_o         sticky: more than one way hit in some compare
module tag_arb_cmp #(
   parameter int unsigned NR_PORTS         = 3,
   parameter int unsigned ADDR_WIDTH       = 64,
   parameter int unsigned TAG_WIDTH        = 44,
   parameter int unsigned LINE_WIDTH       = 128,
   parameter int unsigned DCACHE_SET_ASSOC = 8,
   parameter int unsigned RR_MODE          = 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NR_PORTS*DCACHE_SET_ASSOC-1:0]      req_i,
   input  logic [NR_PORTS-1:0]                       lock_i,
   output logic [NR_PORTS-1:0]                       gnt_o,
   input  logic [NR_PORTS*ADDR_WIDTH-1:0]            addr_i,
   input  logic [NR_PORTS*LINE_WIDTH-1:0]            wdata_i,
   input  logic [NR_PORTS-1:0]                       we_i,
   input  logic [NR_PORTS*(LINE_WIDTH/8)-1:0]        be_i,
   input  logic [NR_PORTS*TAG_WIDTH-1:0]             tag_i,
   output logic [DCACHE_SET_ASSOC-1:0]               req_o,
   output logic [ADDR_WIDTH-1:0]                     addr_o,
   output logic [LINE_WIDTH-1:0]                     wdata_o,
   output logic                                      we_o,
   output logic [LINE_WIDTH/8-1:0]                   be_o,
   input  logic [DCACHE_SET_ASSOC*TAG_WIDTH-1:0]     way_tag_i,
   input  logic [DCACHE_SET_ASSOC-1:0]               way_valid_i,
   input  logic [DCACHE_SET_ASSOC*LINE_WIDTH-1:0]    way_data_i,
   output logic [DCACHE_SET_ASSOC*LINE_WIDTH-1:0]    rdata_o,
   output logic                                      cmp_valid_o,
   output logic [NR_PORTS-1:0]                       cmp_port_o,
   output logic [DCACHE_SET_ASSOC-1:0]               hit_way_o,
   output logic                                      hit_o,
   output logic [((DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1)-1:0] hit_idx_o,
   output logic                                      multi_hit_o
);

   localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
   localparam int unsigned PORT_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
   localparam int unsigned IDX_W    = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;
   localparam int unsigned CNT_W    = IDX_W + 1;

   logic [NR_PORTS-1:0] active;
   logic                lock_valid_q;
   logic [PORT_W-1:0]   lock_owner_q;
   logic [PORT_W-1:0]   rr_q;
   logic                lock_hit;
   logic                gnt_valid;
   logic [PORT_W-1:0]   gnt_idx;
   logic [PORT_W-1:0]   next_rr;
   logic                cmp_pending_q;
   logic [NR_PORTS-1:0] id_q;
   logic                multi_hit_q;
   logic [TAG_WIDTH-1:0] sel_tag;
   logic                cmp_live;
   logic [CNT_W-1:0]    hit_cnt;
   logic                multi_now;

   // Port activity: any way-select bit set.
   always_comb begin
      active = '0;
      for (int p = 0; p < int'(NR_PORTS); p++) begin
         active[p] = |req_i[p*DCACHE_SET_ASSOC +: DCACHE_SET_ASSOC];
      end
   end

   // A lock only holds while its owner keeps requesting.
   assign lock_hit = lock_valid_q & active[lock_owner_q];

   // Grant selection; loops run downward so the lowest-ranked candidate wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (lock_hit) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_owner_q;
      end else if (RR_MODE == 0) begin
         for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
            if (active[i]) begin
               gnt_valid = 1'b1;
               gnt_idx   = PORT_W'(i);
            end
         end
      end else begin
         for (int off = int'(NR_PORTS) - 1; off >= 0; off--) begin
            if (active[(int'(rr_q) + off) % int'(NR_PORTS)]) begin
               gnt_valid = 1'b1;
               gnt_idx   = PORT_W'((int'(rr_q) + off) % int'(NR_PORTS));
            end
         end
      end
   end

   assign next_rr = (gnt_idx == PORT_W'(NR_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);

   // One-hot grant and request-field mux toward the SRAMs.
   always_comb begin
      gnt_o   = '0;
      req_o   = '0;
      addr_o  = '0;
      wdata_o = '0;
      we_o    = 1'b0;
      be_o    = '0;
      for (int p = 0; p < int'(NR_PORTS); p++) begin
         if (gnt_valid && (gnt_idx == PORT_W'(p))) begin
            gnt_o[p] = 1'b1;
            req_o    = req_i[p*DCACHE_SET_ASSOC +: DCACHE_SET_ASSOC];
            addr_o   = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_o  = wdata_i[p*LINE_WIDTH +: LINE_WIDTH];
            we_o     = we_i[p];
            be_o     = be_i[p*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   // Arbiter state, compare stage register and sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_q          <= '0;
         lock_valid_q  <= 1'b0;
         lock_owner_q  <= '0;
         cmp_pending_q <= 1'b0;
         id_q          <= '0;
         multi_hit_q   <= 1'b0;
      end else begin
         if (gnt_valid) begin
            lock_valid_q <= lock_i[gnt_idx];
            lock_owner_q <= gnt_idx;
            if (!lock_hit) begin
               rr_q <= next_rr;
            end
         end else begin
            lock_valid_q <= 1'b0;
         end
         cmp_pending_q <= gnt_valid & ~we_o;
         id_q          <= gnt_o;
         if (multi_now) begin
            multi_hit_q <= 1'b1;
         end
      end
   end

   // Tag of the port granted last cycle.
   always_comb begin
      sel_tag = '0;
      for (int p = 0; p < int'(NR_PORTS); p++) begin
         if (id_q[p]) begin
            sel_tag = sel_tag | tag_i[p*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   // Compare outputs are forced quiet while reset is held.
   assign cmp_live = cmp_pending_q & rst_ni;

   always_comb begin
      hit_way_o = '0;
      hit_idx_o = '0;
      hit_cnt   = '0;
      for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
         hit_way_o[j] = cmp_live & way_valid_i[j] &
                        (way_tag_i[j*TAG_WIDTH +: TAG_WIDTH] == sel_tag);
         hit_cnt      = hit_cnt + CNT_W'(hit_way_o[j]);
      end
      for (int j = int'(DCACHE_SET_ASSOC) - 1; j >= 0; j--) begin
         if (hit_way_o[j]) begin
            hit_idx_o = IDX_W'(j);
         end
      end
   end

   assign multi_now   = (hit_cnt > CNT_W'(1));
   assign hit_o       = |hit_way_o;
   assign cmp_valid_o = cmp_live;
   assign cmp_port_o  = rst_ni ? id_q : '0;
   assign multi_hit_o = multi_hit_q;
   assign rdata_o     = way_data_i;

endmodule
